// File: rtl/clock_generation_pkg.sv
// Shared types for the io clock generator: system clock domain bundle, FSM
// states, rate configuration and the rate clamping rule.
package common_p;
  typedef struct packed {
    logic clk;
    logic rst;
  } clk_dom;
endpackage

package clks_alot_p;
  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    STOPPING
  } clock_gen_state_e;

  // Widest counter supported; instances use the low COUNTER_WIDTH bits.
  localparam int unsigned RATE_WIDTH_MAX = 32;

  localparam logic [RATE_WIDTH_MAX-1:0] MIN_HALF_RATE = 2;

  typedef struct packed {
    logic [RATE_WIDTH_MAX-1:0] half;
    logic [RATE_WIDTH_MAX-1:0] quarter;
  } clock_rate_cfg_s;

  // Half period is at least MIN_HALF_RATE; the quarter point is kept strictly
  // inside the half period so the two strobes never coincide.
  function automatic clock_rate_cfg_s clamp_rate(input logic [RATE_WIDTH_MAX-1:0] half,
                                                 input logic [RATE_WIDTH_MAX-1:0] quarter);
    clock_rate_cfg_s cfg;
    cfg.half = (half < MIN_HALF_RATE) ? MIN_HALF_RATE : half;
    if (quarter == '0) begin
      cfg.quarter = RATE_WIDTH_MAX'(1);
    end else if (quarter >= cfg.half) begin
      cfg.quarter = cfg.half - RATE_WIDTH_MAX'(1);
    end else begin
      cfg.quarter = quarter;
    end
    return cfg;
  endfunction
endpackage

// File: rtl/clock_generation_rate_counter.sv
// Latched-target half-period counter with clamping, wrap and the half/quarter
// strobes. Targets are captured on start and at every half boundary.
module rate_counter
  import clks_alot_p::*;
#(
  parameter int unsigned COUNTER_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     run,
  input  logic [COUNTER_WIDTH-1:0] half_target,
  input  logic [COUNTER_WIDTH-1:0] quarter_target,
  output logic                     half_elapsed,
  output logic                     quarter_elapsed
);

  clock_rate_cfg_s          cfg_next;
  logic                     unused_cfg_bits;
  logic [COUNTER_WIDTH-1:0] half_q;
  logic [COUNTER_WIDTH-1:0] quarter_q;
  logic [COUNTER_WIDTH-1:0] count;
  logic                     wrap;

  assign cfg_next        = clamp_rate(RATE_WIDTH_MAX'(half_target), RATE_WIDTH_MAX'(quarter_target));
  assign unused_cfg_bits = ^cfg_next;

  assign wrap            = (count == half_q - COUNTER_WIDTH'(1));
  assign half_elapsed    = run && wrap;
  assign quarter_elapsed = run && (count == quarter_q - COUNTER_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      half_q    <= COUNTER_WIDTH'(MIN_HALF_RATE);
      quarter_q <= COUNTER_WIDTH'(1);
    end else if (start || (run && wrap)) begin
      count     <= '0;
      half_q    <= cfg_next.half[COUNTER_WIDTH-1:0];
      quarter_q <= cfg_next.quarter[COUNTER_WIDTH-1:0];
    end else if (run) begin
      count <= count + COUNTER_WIDTH'(1);
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/clock_generation.sv
// io clock generator: start/stop sequencing FSM and the registered io clock,
// with phase strobes from the rate counter. Stops only at the idle level.
module clock_generation
  import clks_alot_p::*;
#(
  parameter int unsigned COUNTER_WIDTH = 16
) (
  input  common_p::clk_dom         sys_dom_i,
  input  logic                     clock_enable_i,
  input  logic [COUNTER_WIDTH-1:0] half_rate_target_i,
  input  logic [COUNTER_WIDTH-1:0] quarter_rate_target_i,
  input  logic                     idle_value_i,
  output logic                     clock_active_o,
  output logic                     io_clk_o,
  output logic                     half_rate_elapsed_o,
  output logic                     quarter_rate_elapsed_o
);

  logic             clk;
  logic             rst;
  clock_gen_state_e state;
  clock_gen_state_e state_next;
  logic             io_clk_q;
  logic             idle_q;
  logic             run;
  logic             start;
  logic             half_elapsed;
  logic             quarter_elapsed;

  assign clk   = sys_dom_i.clk;
  assign rst   = sys_dom_i.rst;
  assign run   = (state != IDLE);
  assign start = (state == IDLE) && clock_enable_i;

  rate_counter #(
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_rate_counter (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .run            (run),
    .half_target    (half_rate_target_i),
    .quarter_target (quarter_rate_target_i),
    .half_elapsed   (half_elapsed),
    .quarter_elapsed(quarter_elapsed)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (clock_enable_i) state_next = RUNNING;
      RUNNING:  if (!clock_enable_i) state_next = STOPPING;
      STOPPING: begin
        // Leave only on the boundary whose toggle lands on the idle level.
        if (clock_enable_i) state_next = RUNNING;
        else if (half_elapsed && ((~io_clk_q) == idle_q)) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      io_clk_q <= 1'b0;
      idle_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        io_clk_q <= idle_value_i;
        if (clock_enable_i) idle_q <= idle_value_i;
      end else if (half_elapsed) begin
        io_clk_q <= ~io_clk_q;
      end
    end
  end

  assign clock_active_o         = run;
  assign io_clk_o               = io_clk_q;
  assign half_rate_elapsed_o    = half_elapsed;
  assign quarter_rate_elapsed_o = quarter_elapsed;

endmodule
